// File: rtl/prio_enc_pkg.sv
// Shared defaults for the priority encoder: request width and encoded index width.
package prio_enc_pkg;
    localparam int PE_WIDTH = 8;
    localparam int PE_OUT_W = $clog2(PE_WIDTH);
endpackage

// File: rtl/prio_enc_core.sv
// Combinational search for the most significant set bit of a request vector.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int OUT_W = PE_OUT_W
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [OUT_W-1:0] idx_o,
    output logic             any_o
);
    // Ascending scan: the last set bit seen is the highest, so lower bits never win.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req_i[i]) begin
                idx_o = OUT_W'(i);
            end
        end
    end

    assign any_o = |req_i;
endmodule

// File: rtl/priority_encode.sv
// Registered priority encoder: captures the index of the highest set request bit when enabled.
module priority_encode
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int OUT_W = PE_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [OUT_W-1:0] y,
    output logic             valid
);
    logic [OUT_W-1:0] core_idx;
    logic             core_any;
    logic [OUT_W-1:0] y_d, y_q;
    logic             valid_d, valid_q;

    prio_enc_core #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_core (
        .req_i (in),
        .idx_o (core_idx),
        .any_o (core_any)
    );

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        if (en) begin
            y_d     = core_idx;
            valid_d = core_any;
        end
    end

    // Reset overrides enable and discards whatever request is present on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_priority_encode.sv
// Bench for priority_encode: directed scenarios plus random traffic against a log2 reference model.
module tb_priority_encode;
    logic       clk;
    logic       rst;
    logic [7:0] in;
    logic       en;
    logic [2:0] y;
    logic       valid;

    int n_cmp;
    int n_bad;

    logic [3:0] exp_q[$];   // {valid, y}
    logic [2:0] m_y;
    logic       m_v;

    priority_encode dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .en    (en),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of highest set bit = floor(log2(v)) by repeated halving.
    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        int unsigned t;
        int k;
        t = v;
        k = 0;
        while (t > 1) begin
            t = t >> 1;
            k++;
        end
        return 3'(k);
    endfunction

    task automatic step(input logic r, input logic e, input logic [7:0] v);
        @(negedge clk);
        rst = r;
        en  = e;
        in  = v;
        @(posedge clk);
        if (r) begin
            m_y = 3'd0;
            m_v = 1'b0;
        end else if (e) begin
            m_y = (v == 8'd0) ? 3'd0 : ref_idx(v);
            m_v = (v != 8'd0);
        end
        exp_q.push_back({m_v, m_y});
    endtask

    // Monitor: every edge that has a pending expectation is compared just after the edge.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (y !== e[2:0]) begin
                    n_bad++;
                    $display("FAIL y: got %0d expected %0d (t=%0t)", y, e[2:0], $time);
                end
                n_cmp++;
                if (valid !== e[3]) begin
                    n_bad++;
                    $display("FAIL valid: got %0b expected %0b (t=%0t)", valid, e[3], $time);
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        n_cmp = 0;
        n_bad = 0;
        m_y   = 3'd0;
        m_v   = 1'b0;
        rst   = 1'b1;
        en    = 1'b1;
        in    = 8'd0;

        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b0, 8'h00);

        for (int i = 7; i >= 0; i--) begin
            v = 8'd1 << i;
            step(1'b0, 1'b1, v);
        end
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'b0101_1111);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'b1010_0110);
        step(1'b0, 1'b1, 8'd16);
        step(1'b0, 1'b0, 8'd128);
        step(1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b1, 8'd128);
        step(1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b1, 8'd1);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: v = 8'd0;
                1: v = 8'd1 << $urandom_range(0, 7);
                default: v = 8'($urandom_range(0, 255));
            endcase
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), v);
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/priority_encode.md
PRIORITY_ENCODE -- requirements
Module: priority_encode

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of request bits on in.
REQ-002 The block SHALL have parameter OUT_W, default 3 (= clog2(WIDTH)), giving the width of the encoded index y.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port in, input, WIDTH, the request vector; bit WIDTH-1 is highest priority.
REQ-006 The block SHALL have port en, input, 1, the capture enable; when en is unconnected the integrator ties it to 1.
REQ-007 The block SHALL have port y, output, OUT_W, the registered index of the highest set bit of in.
REQ-008 The block SHALL have port valid, output, 1, registered; high when the captured in had at least one bit set.

Function
REQ-009 On each rising clk edge with rst=0 and en=1, y SHALL load the index of the most significant 1 in in.
REQ-010 Encoding SHALL be one-hot-independent: any lower bits set alongside the winning bit SHALL be ignored (e.g. 8'b1010_0110 gives y=7).
REQ-011 When in=0 and en=1, y SHALL load 0 and valid SHALL load 0.
REQ-012 When in is nonzero and en=1, valid SHALL load 1.
REQ-013 When en=0, y and valid SHALL hold their previous values.
REQ-014 Latency SHALL be exactly one clock: the result for in sampled at edge N is visible on y/valid after edge N and stable until edge N+1.
REQ-015 There SHALL be no combinational path from in to y or valid; both outputs SHALL be driven directly from flops.
REQ-016 y=0 with valid=1 SHALL mean only bit 0 is set; y=0 with valid=0 SHALL mean no request.
REQ-017 For WIDTH not a power of two, y SHALL never exceed WIDTH-1.

Reset
REQ-018 While rst=1 at a rising edge, y SHALL load 0 and valid SHALL load 0, regardless of en and in.
REQ-019 rst SHALL take priority over en.
REQ-020 Reset asserted mid-stream SHALL discard the in sampled on that edge.
REQ-021 The first capture after reset SHALL occur on the first edge with rst=0 and en=1.
REQ-022 Outputs SHALL be undefined only before the first reset edge.

Structure
REQ-023 Default WIDTH/OUT_W constants SHALL live in shared package prio_enc_pkg.
REQ-024 The combinational highest-bit search SHALL be a sub-module prio_enc_core (in -> index, any).
REQ-025 The top SHALL register the prio_enc_core outputs and contain no other logic than the enable and reset muxing.

Verification
REQ-026 The bench SHALL cover this scenario: rst=1 for 2 edges -> y=0, valid=0.
REQ-027 The bench SHALL cover this scenario: en=1, in sweeps 128, 64, 32, 16, 8, 4, 2, 1, one per clock -> y = 7, 6, 5, 4, 3, 2, 1, 0 one clock later, valid=1 each.
REQ-028 The bench SHALL cover this scenario: in=0 -> next clock y=0, valid=0.
REQ-029 The bench SHALL cover this scenario: in=8'b0101_1111 -> y=6; in=8'hFF -> y=7.
REQ-030 The bench SHALL cover this scenario: capture in=16 (y=4), then en=0 with in=128 -> y stays 4, valid stays 1.
REQ-031 The bench SHALL cover this scenario: in=128 with rst=1 and en=1 on the same edge -> y=0, valid=0.
